// File: rtl/lcd_hd44780_pkg.sv
// lcd_hd44780_pkg: shared FSM states and LCD bus constants
package lcd_hd44780_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, POLL, DONE} lcd_state_t;
  localparam int BF_BIT = 7;
  localparam logic RS_CMD = 1'b0;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ = 1'b1;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/lcd_hd44780_timed_ctrl_phase_timer.sv
// lcd_phase_timer: loadable down-counter that parks at zero and flags it
module lcd_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  // load wins; otherwise count down and stop at zero
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/lcd_hd44780_timed_ctrl.sv
// lcd_hd44780_timed_ctrl: Avalon-MM slave generating HD44780 bus timing with optional busy polling
module lcd_hd44780_timed_ctrl
  import lcd_hd44780_pkg::*;
#(
  parameter int BUS_4BIT = 0,
  parameter int T_AS = 2,
  parameter int T_PW = 12,
  parameter int T_H = 2,
  parameter int BUSY_POLL = 0,
  parameter int POLL_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       busy_timeout,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);
  localparam int W = $clog2(max3(T_AS, T_PW, T_H)) + 1;
  lcd_state_t state;
  logic [7:0] wdata, data_out, data_in, pcnt;
  logic [W-1:0] load_val;
  logic nib, wr_op, polling, bf, zero, load, data_oe, last_nib;
  assign last_nib = BUS_4BIT == 0 || nib;
  assign load = (state == IDLE && (read || write)) || state == POLL ||
                (zero && (state == SETUP || state == PULSE || state == HOLD));
  assign load_val = W'(state == SETUP ? T_PW - 1 : state == PULSE ? T_H - 1 : T_AS - 1);
  assign data_out = BUS_4BIT == 0 ? wdata : {nib ? wdata[3:0] : wdata[7:4], 4'h0};
  assign data_oe = state != IDLE && LCD_RW == RW_WRITE;
  assign LCD_data = data_oe ? data_out : 'z;
  assign data_in = LCD_data;
  assign waitrequest = (read || write) && state != DONE;
  lcd_phase_timer #(.W(W)) u_timer (
    .clk(clk), .rst(reset), .load(load), .load_val(load_val), .zero(zero)
  );
  // transaction sequencer: setup/pulse/hold per nibble, then optional BF polling
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      LCD_E <= 1'b0;
      LCD_RS <= 1'b0;
      LCD_RW <= 1'b0;
      readdata <= '0;
      busy_timeout <= 1'b0;
      wdata <= '0;
      nib <= 1'b0;
      wr_op <= 1'b0;
      polling <= 1'b0;
      bf <= 1'b0;
      pcnt <= '0;
    end else
      case (state)
        IDLE: if (read || write) begin
          state <= SETUP;
          LCD_RS <= address[1];
          LCD_RW <= address[0];
          wdata <= writedata;
          wr_op <= !read;
          busy_timeout <= 1'b0;
          nib <= 1'b0;
          polling <= 1'b0;
          pcnt <= '0;
        end
        SETUP: if (zero) begin
          state <= PULSE;
          LCD_E <= 1'b1;
        end
        PULSE: if (zero) begin
          state <= HOLD;
          LCD_E <= 1'b0;
          if (LCD_RW) begin
            if (BUS_4BIT == 0) readdata <= data_in;
            else if (nib) readdata[3:0] <= data_in[7:4];
            else readdata[7:4] <= data_in[7:4];
            if (!nib) bf <= data_in[BF_BIT];
          end
        end
        HOLD: if (zero) begin
          nib <= !last_nib;
          if (!last_nib) state <= SETUP;
          else if (BUSY_POLL == 0 || !wr_op || (polling && !bf)) state <= DONE;
          else if (polling && int'(pcnt) + 1 >= POLL_MAX) begin
            busy_timeout <= 1'b1;
            state <= DONE;
          end else begin
            state <= POLL;
            polling <= 1'b1;
            LCD_RS <= RS_CMD;
            LCD_RW <= RW_READ;
            if (polling && pcnt != 8'hff) pcnt <= pcnt + 8'd1;
          end
        end
        POLL: state <= SETUP;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_lcd_hd44780_timed_ctrl.sv
// tb_lcd_hd44780_timed_ctrl: vector table, random transactions and corner sequences on three configurations
module tb_lcd_hd44780_timed_ctrl;
  localparam int T_AS = 2, T_PW = 12, P = 16, PMAX = 4;
  typedef struct {
    int in;
    logic rd, wr;
    logic [1:0] ad;
    logic [7:0] v;
    int bfr, lat;
    logic [7:0] rdat;
    logic to;
  } vec_t;
  logic clk = 0, reset = 1, read = 0, write = 0;
  logic [1:0] address = 0;
  logic [7:0] writedata = 0, drv_val = 0;
  int inst = 0, checks = 0, failures = 0;
  logic [2:0] rq_rd, rq_wr;
  wire [2:0] wreq, bto, e, rs, rw;
  wire [7:0] rdata0, rdata1, rdata2, bus0, bus1, bus2;
  logic [7:0] s_bus, s_rd;
  logic s_wr, s_bto, s_e, s_rs, s_rw, s_oe;
  vec_t tbl[9];
  always #5 clk = ~clk;
  assign rq_rd = {inst == 2, inst == 1, inst == 0} & {3{read}};
  assign rq_wr = {inst == 2, inst == 1, inst == 0} & {3{write}};
  assign bus0 = (inst == 0 && rw[0]) ? drv_val : 'z;
  assign bus1 = (inst == 1 && rw[1]) ? drv_val : 'z;
  assign bus2 = (inst == 2 && rw[2]) ? drv_val : 'z;
  always_comb begin
    s_bus = inst == 0 ? bus0 : inst == 1 ? bus1 : bus2;
    s_rd = inst == 0 ? rdata0 : inst == 1 ? rdata1 : rdata2;
    s_oe = inst == 0 ? u0.data_oe : inst == 1 ? u1.data_oe : u2.data_oe;
    s_wr = wreq[inst[1:0]];
    s_bto = bto[inst[1:0]];
    s_e = e[inst[1:0]];
    s_rs = rs[inst[1:0]];
    s_rw = rw[inst[1:0]];
  end
  lcd_hd44780_timed_ctrl u0 (
    .clk(clk), .reset(reset), .address(address), .read(rq_rd[0]), .write(rq_wr[0]),
    .writedata(writedata), .readdata(rdata0), .waitrequest(wreq[0]), .busy_timeout(bto[0]),
    .LCD_E(e[0]), .LCD_RS(rs[0]), .LCD_RW(rw[0]), .LCD_data(bus0)
  );
  lcd_hd44780_timed_ctrl #(.BUS_4BIT(1)) u1 (
    .clk(clk), .reset(reset), .address(address), .read(rq_rd[1]), .write(rq_wr[1]),
    .writedata(writedata), .readdata(rdata1), .waitrequest(wreq[1]), .busy_timeout(bto[1]),
    .LCD_E(e[1]), .LCD_RS(rs[1]), .LCD_RW(rw[1]), .LCD_data(bus1)
  );
  lcd_hd44780_timed_ctrl #(.BUSY_POLL(1), .POLL_MAX(PMAX)) u2 (
    .clk(clk), .reset(reset), .address(address), .read(rq_rd[2]), .write(rq_wr[2]),
    .writedata(writedata), .readdata(rdata2), .waitrequest(wreq[2]), .busy_timeout(bto[2]),
    .LCD_E(e[2]), .LCD_RS(rs[2]), .LCD_RW(rw[2]), .LCD_data(bus2)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int nw(input int in);
    return in == 1 ? 2 : 1;
  endfunction

  // number of busy-flag reads the LCD sees after a write on the polling instance
  function automatic int model_polls(input int in, input logic rd, input int bfr);
    if (in != 2 || rd) return 0;
    return bfr >= PMAX ? PMAX : bfr + 1;
  endfunction

  // what the LCD puts on the bus for E pulse number np of a transaction
  function automatic logic [7:0] pulse_val(input int in, input logic rd, input logic [7:0] v,
                                           input int bfr, input int np);
    int n, j;
    n = nw(in);
    if (rd) return n == 1 ? v : (np % n == 0 ? {v[7:4], 4'h0} : {v[3:0], 4'h0});
    j = np / n - 1;
    return (j >= 0 && j < bfr && np % n == 0) ? 8'h80 : 8'h00;
  endfunction

  function automatic vec_t model_vec(input int in, input logic rd, input logic wr, input logic [1:0] ad,
                                     input logic [7:0] v, input int bfr);
    vec_t t;
    int n, pol;
    n = nw(in);
    pol = model_polls(in, rd, bfr);
    t.in = in; t.rd = rd; t.wr = wr; t.ad = ad; t.v = v; t.bfr = bfr;
    t.lat = 1 + n * P + pol * (1 + n * P);
    t.rdat = v;
    t.to = in == 2 && !rd && bfr >= PMAX;
    return t;
  endfunction

  task automatic run_txn(input vec_t t);
    int k, np, hi, pol, n, nib;
    logic pe, drove;
    n = nw(t.in);
    pol = model_polls(t.in, t.rd, t.bfr);
    inst = t.in; address = t.ad; writedata = t.v; read = t.rd; write = t.wr;
    np = 0; hi = 0; pe = 0; drove = 0;
    drv_val = pulse_val(t.in, t.rd, t.v, t.bfr, 0);
    for (k = 1; k <= 2000; k++) begin
      @(posedge clk);
      @(negedge clk);
      drove |= s_oe && t.rd;
      if (!t.rd && k <= n * P) begin
        nib = (k - 1) / P;
        check("wdata", n == 1 ? int'(s_bus) : int'(s_bus[7:4]),
              n == 1 ? int'(t.v) : nib != 0 ? int'(t.v[3:0]) : int'(t.v[7:4]));
      end
      if (s_e) begin
        if (!pe && np == 0) check("setup", k, 1 + T_AS);
        if (!pe) begin
          check("rs", s_rs, np < n ? t.ad[1] : 1'b0);
          check("rw", s_rw, np < n ? t.ad[0] : 1'b1);
        end
        hi++;
      end else if (pe) begin
        check("e_width", hi, T_PW);
        hi = 0;
        np++;
        drv_val = pulse_val(t.in, t.rd, t.v, t.bfr, np);
      end
      pe = s_e;
      if (!s_wr) break;
    end
    read = 0;
    write = 0;
    check("latency", k, t.lat);
    check("pulses", np, n * (1 + pol));
    if (t.rd) begin
      check("readdata", s_rd, t.rdat);
      check("bus_released", drove, 0);
    end
    check("busy_timeout", s_bto, t.to);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int k, rise, first, second, nd, np;
    logic pe, rd;
    tbl[0] = '{0, 0, 1, 2'b10, 8'h41, 0, 17, 8'h00, 0};
    tbl[1] = '{0, 1, 0, 2'b11, 8'hA5, 0, 17, 8'hA5, 0};
    tbl[2] = '{0, 1, 1, 2'b01, 8'h5C, 0, 17, 8'h5C, 0};
    tbl[3] = '{1, 0, 1, 2'b00, 8'h3C, 0, 33, 8'h00, 0};
    tbl[4] = '{1, 1, 0, 2'b11, 8'h96, 0, 33, 8'h96, 0};
    tbl[5] = '{2, 0, 1, 2'b00, 8'h01, 3, 85, 8'h00, 0};
    tbl[6] = '{2, 0, 1, 2'b10, 8'h55, 255, 85, 8'h00, 1};
    tbl[7] = '{2, 0, 1, 2'b00, 8'h02, 0, 34, 8'h00, 0};
    tbl[8] = '{2, 1, 0, 2'b11, 8'h7E, 0, 17, 8'h7E, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      inst = i;
      #1;
      check("rst_e", s_e, 0);
      check("rst_rs", s_rs, 0);
      check("rst_rw", s_rw, 0);
      check("rst_readdata", s_rd, 0);
      check("rst_timeout", s_bto, 0);
      check("rst_wait", s_wr, 0);
      check("rst_oe", s_oe, 0);
    end
    @(negedge clk);
    foreach (tbl[i]) run_txn(tbl[i]);
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom_range(0, 1));
      run_txn(model_vec($urandom_range(0, 2), rd, rd ? 1'($urandom_range(0, 1)) : 1'b1,
                        {1'($urandom_range(0, 1)), rd}, 8'($urandom), $urandom_range(0, 5)));
    end
    inst = 0; address = 2'b10; writedata = 8'h41; write = 1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pulse_before_reset", s_e, 1);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    check("e_after_reset", s_e, 0);
    check("bus_after_reset", s_oe, 0);
    check("wait_after_reset", s_wr, 1);
    rise = 0;
    for (k = 8; k <= 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (s_e && rise == 0) rise = k;
      if (!s_wr) break;
    end
    write = 0;
    check("restart_rise", rise, 10);
    check("restart_done", k, 24);
    @(posedge clk);
    @(negedge clk);
    address = 2'b00; writedata = 8'h38; write = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    write = 0;
    np = 0;
    pe = s_e;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (pe && !s_e) np++;
      pe = s_e;
    end
    check("drop_pulses", np, 1);
    check("drop_wait", s_wr, 0);
    run_txn(tbl[0]);
    write = 1;
    nd = 0; first = -10; second = 0;
    for (k = 1; k <= 100 && nd < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (nd == 1 && k == first + 1) check("b2b_not_reaccepted", s_wr, 1);
      if (!s_wr) begin
        nd++;
        if (nd == 1) first = k;
        else second = k;
      end
    end
    write = 0;
    check("b2b_first_done", first, 17);
    check("b2b_second_done", second, 35);
    @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
